// File: rtl/posit_decode_pipe.sv
// posit_decode_pipe: two-stage pipelined posit field decoder behind a
// valid/ready stream. Stage 1 normalises the sign and measures the regime
// run. Stage 2 extracts the regime, exponent, mantissa and scale into the
// registered output ports. When ES is 0 the Exponent port is one bit wide
// and always reads 0.
module posit_decode_pipe #(
  parameter int N  = 8,
  parameter int ES = 2,
  parameter int RS = $clog2(N),
  localparam int EW = (ES > 0) ? ES : 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [N-1:0]         In,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic                 Sign,
  output logic signed [RS:0]   RegimeValue,
  output logic [EW-1:0]        Exponent,
  output logic [N-1:0]         Mantissa,
  output logic signed [RS+ES:0] Scale,
  output logic                 IsZero,
  output logic                 IsNaR
);

  localparam int BW = N - 1;          // body width below the sign bit
  localparam int SW = RS + ES + 1;    // scale width
  localparam logic [N-1:0] NAR_WORD = {1'b1, {(N-1){1'b0}}};

  // Stage-1 registers
  logic              s1_valid_r;
  logic              s1_sign_r;
  logic [BW-1:0]     s1_mag_r;
  logic              s1_lead_r;
  logic [RS-1:0]     s1_run_r;
  logic              s1_zero_r;
  logic              s1_nar_r;

  // Stage-1 combinational results
  logic [BW-1:0]     mag_s;
  logic [RS-1:0]     run_s;
  logic              done_s;
  logic              zero_s;
  logic              nar_s;

  // Stage-2 combinational results
  logic [RS:0]       run_ext_s;
  logic [RS:0]       shamt_s;
  logic [BW-1:0]     rem_s;
  logic signed [RS:0] regime_s;
  logic [EW-1:0]     exp_s;
  logic [N-1:0]      mant_s;
  logic signed [SW-1:0] scale_s;
  logic              sign_s;

  // Handshake
  logic              s2_load_s;
  logic              s1_load_s;

  assign s2_load_s = ~OutValid | OutReady;
  assign s1_load_s = ~s1_valid_r | s2_load_s;
  assign InReady   = s1_load_s;

  // Stage 1: fold negative posits to magnitude and measure the regime run
  always_comb begin
    zero_s = (In == {N{1'b0}});
    nar_s  = (In == NAR_WORD);
    if (In[N-1]) begin
      mag_s = ~In[N-2:0] + BW'(1);
    end else begin
      mag_s = In[N-2:0];
    end
    run_s  = {RS{1'b0}};
    done_s = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!done_s && (mag_s[i] == mag_s[N-2])) begin
        run_s = run_s + RS'(1);
      end else begin
        done_s = 1'b1;
      end
    end
  end

  // Stage-1 register: captures the body whenever the stage may advance
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_valid_r <= 1'b0;
      s1_sign_r  <= 1'b0;
      s1_mag_r   <= {BW{1'b0}};
      s1_lead_r  <= 1'b0;
      s1_run_r   <= {RS{1'b0}};
      s1_zero_r  <= 1'b0;
      s1_nar_r   <= 1'b0;
    end else if (s1_load_s) begin
      s1_valid_r <= InValid;
      s1_sign_r  <= In[N-1];
      s1_mag_r   <= mag_s;
      s1_lead_r  <= mag_s[BW-1];
      s1_run_r   <= run_s;
      s1_zero_r  <= zero_s;
      s1_nar_r   <= nar_s;
    end
  end

  // Stage 2: strip regime plus terminator, then split exponent and fraction
  always_comb begin
    run_ext_s = {1'b0, s1_run_r};
    // a run that reaches the LSB shifts everything out, so no terminator case
    shamt_s   = run_ext_s + (RS+1)'(1);
    rem_s     = s1_mag_r << shamt_s;
    if (s1_zero_r || s1_nar_r) begin
      sign_s   = s1_nar_r;
      regime_s = '0;
      exp_s    = {EW{1'b0}};
      mant_s   = {N{1'b0}};
      scale_s  = '0;
    end else begin
      sign_s = s1_sign_r;
      if (s1_lead_r) begin
        regime_s = run_ext_s - (RS+1)'(1);
      end else begin
        regime_s = (RS+1)'(0) - run_ext_s;
      end
      exp_s   = EW'(rem_s >> (BW - ES));
      mant_s  = {1'b1, BW'(rem_s << ES)};
      scale_s = (SW'(regime_s) <<< ES) + $signed(SW'(exp_s));
    end
  end

  // Stage-2 register: output ports, held while the consumer stalls
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      OutValid    <= 1'b0;
      Sign        <= 1'b0;
      RegimeValue <= '0;
      Exponent    <= {EW{1'b0}};
      Mantissa    <= {N{1'b0}};
      Scale       <= '0;
      IsZero      <= 1'b0;
      IsNaR       <= 1'b0;
    end else if (s2_load_s) begin
      OutValid <= s1_valid_r;
      if (s1_valid_r) begin
        Sign        <= sign_s;
        RegimeValue <= regime_s;
        Exponent    <= exp_s;
        Mantissa    <= mant_s;
        Scale       <= scale_s;
        IsZero      <= s1_zero_r;
        IsNaR       <= s1_nar_r;
      end
    end
  end

endmodule

// File: doc/posit_decode_pipe.md
Name: posit_decode_pipe

Overview:
- Parametrised, pipelined successor to the combinational posit field extractor.
- Takes one N-bit posit per accepted transfer. Returns its fields on a valid/ready stream: sign, regime, exponent, hidden-bit mantissa, combined scale, zero flag and NaR flag.
- Sits in front of the posit arithmetic units; supports back-pressure without dropping or duplicating data.

Parameters:
- N, 8, posit word width; legal range 4..32.
- ES, 2, exponent field width; legal range 0..N-3.
- RS, log2(N) (ceiling), regime magnitude width; derived, do not override.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- InValid  in  1  input word present.
- InReady  out  1  block can accept the input word this cycle.
- In  in  N  posit word.
- OutValid  out  1  decoded result present.
- OutReady  in  1  downstream accepts the result this cycle.
- Sign  out  1  posit sign bit.
- RegimeValue  out  RS+1 signed  regime k.
- Exponent  out  ES  exponent field; missing low bits are zero.
- Mantissa  out  N  bit N-1 is the hidden 1; fraction is left-aligned below it and zero-padded.
- Scale  out  RS+ES+1 signed  RegimeValue*2^ES + Exponent.
- IsZero  out  1  input was 0.
- IsNaR  out  1  input was 1 followed by all zeros.

Behaviour:
- Reset:
  - Asserting Reset clears both stage valids and all output registers to 0 immediately; InReady reads 1.
  - Any data in flight is discarded. No partial result appears after deassertion.
- Pipeline: two register stages; latency is exactly 2 cycles from input transfer to OutValid when unstalled.
  - S1 registers: sign; two's-complement magnitude of In[N-2:0] when sign=1; leading-run bit; run length k (1..N-1); zero/NaR flags.
  - S2 registers: all output ports.
- Handshakes:
  - Input transfer occurs when InValid & InReady. Output transfer occurs when OutValid & OutReady.
  - S2 loads when S2 is empty or OutReady=1.
  - S1 loads when S1 is empty or S2 loads.
  - InReady = ~S1valid | S2load. InReady is combinational and must not depend on InValid.
- Stall: while OutValid=1 and OutReady=0, all outputs hold stable. Full throughput is one word per cycle when OutReady is held at 1.
- Regime decode:
  - Leading bit 1: RegimeValue = k-1. Leading bit 0: RegimeValue = -k.
  - The terminating bit is consumed if present. A run reaching the LSB has no terminator.
- Exponent/fraction:
  - Remaining bits after the regime are taken left-to-right: ES exponent bits, then fraction.
  - Truncated exponent bits read as 0. Mantissa = {1, fraction, zeros}.
- Special cases:
  - In=0: IsZero=1; Sign, RegimeValue, Exponent, Mantissa and Scale are all 0.
  - In=1<<(N-1): IsNaR=1, Sign=1, all other fields 0.
  - IsZero and IsNaR are never both 1.
- Simultaneous events:
  - An input transfer and an output transfer in the same cycle are both honoured; occupancy is unchanged.
  - Reset overrides all handshakes.
- Width rule: Scale is sign-extended arithmetic with no overflow for any legal N and ES.

Test Plan (N=8, ES=2, OutReady=1 unless stated):
- Reset mid-stream with two words in flight -> OutValid=0 and all outputs 0 at once. The first output after release is the first word sent after release.
- In=0x40, then 0xC0 back-to-back -> two cycles later, consecutive results:
  - 0x40: Sign=0, Regime=0, Exp=0, Mantissa=0x80, Scale=0.
  - 0xC0: Sign=1, other fields identical.
- In=0x5B -> Regime=0, Exp=3, Mantissa=0xB0, Scale=3.
- In=0x27 -> Regime=-1, Exp=0, Mantissa=0xF0, Scale=-4.
- In=0x7F, 0x01, 0x00, 0x80:
  - 0x7F: Regime=6, Exp=0, Scale=24.
  - 0x01: Regime=-6, Scale=-24.
  - 0x00: IsZero=1, all fields 0.
  - 0x80: IsNaR=1, Sign=1.
- OutReady=0 with three words offered -> two are accepted, then InReady=0. Outputs hold the first result stable. Raising OutReady drains all three in order on consecutive cycles with no loss or duplication.
